// File: rtl/nn_rgb_pkg.sv
// Shared constants and types for the RGB565 camera capture path.
// Frame geometry defaults, address/counter widths and the capture FSM state type.
package nn_rgb_pkg;

  localparam int unsigned H_PIXELS_DEF = 320;
  localparam int unsigned V_LINES_DEF  = 240;
  localparam int unsigned FRAME_SIZE   = H_PIXELS_DEF * V_LINES_DEF;

  // The frame buffer is at most 128K pixels; counters carry one extra bit so
  // they can hold a value equal to a 128K line length without wrapping.
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned CNT_W  = 18;

  typedef enum logic [1:0] {
    StIdle,
    StWaitFrame,
    StCapture,
    StDone
  } cap_state_e;

  function automatic int unsigned calc_frame_size(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Two-stage input register with rise/fall detection.
// s1 is the once-registered input; edges compare s1 against the second stage.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic s1_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = sig_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign s1_o   = s1_q;
  assign rise_o = s1_q & ~s2_q;
  assign fall_o = ~s1_q & s2_q;

endmodule

// File: rtl/capture_ctrl.sv
// Camera capture controller: packs byte pairs into RGB565 pixels and writes them
// to a frame buffer, one frame per vsync low period, with overflow detection.
module capture_ctrl
  import nn_rgb_pkg::*;
#(
  parameter int unsigned H_PIXELS = H_PIXELS_DEF,
  parameter int unsigned V_LINES  = V_LINES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              vsync_i,
  input  logic              href_i,
  input  logic [7:0]        data_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [15:0]       pixel_o,
  output logic              we_o,
  output logic              frame_done_o,
  output logic              busy_o,
  output logic              overflow_o
);

  // H_PIXELS * V_LINES must not exceed 131072 (17-bit address space).
  localparam int unsigned       FrameSize = calc_frame_size(H_PIXELS, V_LINES);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(FrameSize - 1);
  localparam logic [CNT_W-1:0]  HMax      = CNT_W'(H_PIXELS);
  localparam logic [CNT_W-1:0]  VMax      = CNT_W'(V_LINES);

  logic vs_s1, vs_rise, vs_fall;
  logic hr_s1, hr_rise, hr_fall;

  edge_det u_vsync_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (vsync_i),
    .s1_o   (vs_s1),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  edge_det u_href_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (href_i),
    .s1_o   (hr_s1),
    .rise_o (hr_rise),
    .fall_o (hr_fall)
  );

  cap_state_e        state_d, state_q;
  logic [7:0]        data_s1_d, data_s1_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [ADDR_W-1:0] addr_out_d, addr_out_q;
  logic [15:0]       pixel_d, pixel_q;
  logic              we_d, we_q;
  logic              done_d, done_q;
  logic              busy_d, busy_q;
  logic              ovf_d, ovf_q;
  logic [CNT_W-1:0]  pix_cnt_d, pix_cnt_q;
  logic [CNT_W-1:0]  line_cnt_d, line_cnt_q;
  logic              phase_d, phase_q;
  logic [7:0]        hi_d, hi_q;
  logic              cmp_d, cmp_q;
  logic [15:0]       cmp_pix_d, cmp_pix_q;
  logic              phase_cur;

  always_comb begin
    state_d    = state_q;
    data_s1_d  = data_i;
    addr_d     = addr_q;
    addr_out_d = addr_out_q;
    pixel_d    = pixel_q;
    we_d       = 1'b0;
    ovf_d      = ovf_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    phase_d    = phase_q;
    hi_d       = hi_q;
    cmp_d      = 1'b0;
    cmp_pix_d  = cmp_pix_q;
    // The first byte of a line is always a high byte.
    phase_cur  = hr_rise ? 1'b0 : phase_q;

    // Write stage: one cycle behind pixel completion.
    if (cmp_q && enable_i) begin
      we_d       = 1'b1;
      pixel_d    = cmp_pix_q;
      addr_out_d = addr_q;
      if (addr_q != LastAddr) begin
        addr_d = addr_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = StWaitFrame;
        end
      end
      StWaitFrame: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (vs_fall) begin
          state_d    = StCapture;
          addr_d     = '0;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          phase_d    = 1'b0;
          ovf_d      = 1'b0;
        end
      end
      StCapture: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (vs_rise) begin
          state_d = StDone;
        end else if (!vs_fall) begin
          if (hr_fall) begin
            phase_d   = 1'b0;
            pix_cnt_d = '0;
            if (line_cnt_q < VMax) begin
              line_cnt_d = line_cnt_q + 1'b1;
            end
          end else if (hr_s1 && !vs_s1) begin
            if (!phase_cur) begin
              hi_d    = data_s1_q;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (pix_cnt_q < HMax && line_cnt_q < VMax) begin
                cmp_d     = 1'b1;
                cmp_pix_d = {hi_q, data_s1_q};
              end else begin
                ovf_d = 1'b1;
              end
              if (pix_cnt_q < HMax) begin
                pix_cnt_d = pix_cnt_q + 1'b1;
              end
            end
          end
        end
      end
      StDone: begin
        state_d = enable_i ? StWaitFrame : StIdle;
      end
    endcase

    busy_d = (state_d == StWaitFrame) || (state_d == StCapture);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      data_s1_q  <= '0;
      addr_q     <= '0;
      addr_out_q <= '0;
      pixel_q    <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      cmp_q      <= 1'b0;
      cmp_pix_q  <= '0;
    end else begin
      state_q    <= state_d;
      data_s1_q  <= data_s1_d;
      addr_q     <= addr_d;
      addr_out_q <= addr_out_d;
      pixel_q    <= pixel_d;
      we_q       <= we_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      cmp_q      <= cmp_d;
      cmp_pix_q  <= cmp_pix_d;
    end
  end

  assign addr_o       = addr_out_q;
  assign pixel_o      = pixel_q;
  assign we_o         = we_q;
  assign frame_done_o = done_q;
  assign busy_o       = busy_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a 4x2 frame: nominal, odd bytes, overflow,
// write latency, abort, and asynchronous reset mid-frame.
module tb_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic        vsync_i;
  logic        href_i;
  logic [7:0]  data_i;
  logic [16:0] addr_o;
  logic [15:0] pixel_o;
  logic        we_o;
  logic        frame_done_o;
  logic        busy_o;
  logic        overflow_o;

  int tests = 0;
  int fails = 0;

  int          wr_n   = 0;
  int          done_n = 0;
  logic [16:0] wr_addr [64];
  logic [15:0] wr_pix  [64];

  int a0, dn0;

  always #5 clk = ~clk;

  capture_ctrl #(
    .H_PIXELS (4),
    .V_LINES  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .vsync_i      (vsync_i),
    .href_i       (href_i),
    .data_i       (data_i),
    .addr_o       (addr_o),
    .pixel_o      (pixel_o),
    .we_o         (we_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o)
  );

  // Records every write and frame_done pulse, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (we_o === 1'b1 && wr_n < 64) begin
      wr_addr[wr_n] = addr_o;
      wr_pix[wr_n]  = pixel_o;
      wr_n++;
    end
    if (frame_done_o === 1'b1) done_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    vsync_i = vs;
    href_i  = hr;
    data_i  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(vsync_i, 1'b0, 8'h00);
  endtask

  task automatic new_frame();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_frame();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_line(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 8'(int'(start) + i));
    idle(4);
  endtask

  initial begin
    rst_n    = 1'b1;
    enable_i = 1'b0;
    vsync_i  = 1'b1;
    href_i   = 1'b0;
    data_i   = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(addr_o), 32'h0);
    chk("rst_pixel", 32'(pixel_o), 32'h0);
    chk("rst_we", 32'(we_o), 32'h0);
    chk("rst_done", 32'(frame_done_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_ovf", 32'(overflow_o), 32'h0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_busy", 32'(busy_o), 32'h0);
    enable_i = 1'b1;
    idle(3);
    chk("wait_busy", 32'(busy_o), 32'h1);

    // Nominal frame: two full lines, bytes 0x00..0x0F.
    new_frame();
    a0  = wr_n;
    dn0 = done_n;
    send_line(8'h00, 8);
    send_line(8'h08, 8);
    end_frame();
    chk("nom_count", 32'(wr_n - a0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("nom_addr", 32'(wr_addr[a0+i]), 32'(i));
      chk("nom_pix", 32'(wr_pix[a0+i]), {16'h0, 8'(2 * i), 8'(2 * i + 1)});
    end
    chk("nom_done", 32'(done_n - dn0), 32'd1);
    chk("nom_ovf", 32'(overflow_o), 32'h0);

    // Odd byte count: dangling high byte dropped, next line restarts at phase 0.
    new_frame();
    a0  = wr_n;
    dn0 = done_n;
    send_line(8'h10, 7);
    send_line(8'h20, 2);
    chk("odd_count", 32'(wr_n - a0), 32'd4);
    chk("odd_pix2", 32'(wr_pix[a0+2]), 32'h1415);
    chk("odd_addr3", 32'(wr_addr[a0+3]), 32'd3);
    chk("odd_pix3", 32'(wr_pix[a0+3]), 32'h2021);
    end_frame();
    chk("odd_done", 32'(done_n - dn0), 32'd1);
    chk("odd_ovf", 32'(overflow_o), 32'h0);

    // Overflow: 10 bytes on a 4-pixel line.
    new_frame();
    a0  = wr_n;
    dn0 = done_n;
    send_line(8'h30, 10);
    chk("ovf_count", 32'(wr_n - a0), 32'd4);
    chk("ovf_addr3", 32'(wr_addr[a0+3]), 32'd3);
    chk("ovf_pix3", 32'(wr_pix[a0+3]), 32'h3637);
    chk("ovf_flag", 32'(overflow_o), 32'h1);
    end_frame();
    chk("ovf_done", 32'(done_n - dn0), 32'd1);
    chk("ovf_hold", 32'(overflow_o), 32'h1);
    new_frame();
    chk("ovf_clear", 32'(overflow_o), 32'h0);

    // Latency: completing byte sampled at edge k, we_o only after edge k+2.
    a0  = wr_n;
    dn0 = done_n;
    drive(1'b0, 1'b1, 8'h40);
    drive(1'b0, 1'b1, 8'h41);
    @(posedge clk); #1;
    chk("lat_k0", 32'(we_o), 32'h0);
    drive(1'b0, 1'b0, 8'h00);
    @(posedge clk); #1;
    chk("lat_k1", 32'(we_o), 32'h0);
    @(posedge clk); #1;
    chk("lat_k2", 32'(we_o), 32'h1);
    chk("lat_addr", 32'(addr_o), 32'd0);
    chk("lat_pix", 32'(pixel_o), 32'h4041);
    @(posedge clk); #1;
    chk("lat_k3", 32'(we_o), 32'h0);
    idle(3);

    // Abort mid-line: the pixel 0x5253 in flight must not be written.
    drive(1'b0, 1'b1, 8'h50);
    drive(1'b0, 1'b1, 8'h51);
    drive(1'b0, 1'b1, 8'h52);
    drive(1'b0, 1'b1, 8'h53);
    @(negedge clk);
    enable_i = 1'b0;
    data_i   = 8'h54;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy_o), 32'h0);
    drive(1'b0, 1'b1, 8'h55);
    drive(1'b0, 1'b1, 8'h56);
    idle(3);
    end_frame();
    chk("abort_count", 32'(wr_n - a0), 32'd2);
    chk("abort_pix1", 32'(wr_pix[a0+1]), 32'h5051);
    chk("abort_addr1", 32'(wr_addr[a0+1]), 32'd1);
    chk("abort_nodone", 32'(done_n - dn0), 32'd0);

    // Re-enable: bytes before a fresh vsync fall are ignored, address restarts.
    @(negedge clk);
    enable_i = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'(8'h58 + i));
    idle(3);
    chk("reen_busy", 32'(busy_o), 32'h1);
    chk("reen_nowr", 32'(wr_n - a0), 32'd2);
    new_frame();
    a0 = wr_n;
    send_line(8'h60, 2);
    send_line(8'h70, 10);
    chk("reen_count", 32'(wr_n - a0), 32'd5);
    chk("reen_addr0", 32'(wr_addr[a0]), 32'd0);
    chk("reen_pix0", 32'(wr_pix[a0]), 32'h6061);
    chk("reen_addr4", 32'(wr_addr[a0+4]), 32'd4);
    chk("reen_pix4", 32'(wr_pix[a0+4]), 32'h7677);
    chk("reen_ovf", 32'(overflow_o), 32'h1);
    chk("pre_rst_addr", 32'(addr_o), 32'd4);

    // Asynchronous reset in the middle of a clock period.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(addr_o), 32'h0);
    chk("arst_pixel", 32'(pixel_o), 32'h0);
    chk("arst_we", 32'(we_o), 32'h0);
    chk("arst_done", 32'(frame_done_o), 32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    chk("arst_ovf", 32'(overflow_o), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // vsync held low across reset: no fall edge, so no capture.
    a0 = wr_n;
    idle(2);
    send_line(8'h80, 4);
    chk("post_rst_nowr", 32'(wr_n - a0), 32'd0);
    chk("post_rst_busy", 32'(busy_o), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
